// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared state encoding, result flags and default timing constants for the drag tree
package race_pkg;

  localparam int DEF_AMBER_CYCLES   = 3;
  localparam int DEF_TIMEOUT_CYCLES = 15;
  localparam int DEF_CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AMBER  = 2'd1,
    GO     = 2'd2,
    RESULT = 2'd3
  } race_state_t;

  typedef struct packed {
    logic foul_a;
    logic foul_b;
    logic win_a;
    logic win_b;
    logic tie;
    logic timeout;
  } race_flags_t;

endpackage

// File: rtl/race_cycle_counter.sv
// rtl/race_cycle_counter.sv - cycle counter with synchronous clear, enable and saturation at all-ones
module race_cycle_counter
  import race_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/drag_tree_controller.sv
// rtl/drag_tree_controller.sv - drag race light tree: staging, amber countdown, launch judging and result hold
module drag_tree_controller
  import race_pkg::*;
#(
  parameter int AMBER_CYCLES   = DEF_AMBER_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STAGE_A,
  input  logic             STAGE_B,
  input  logic             LAUNCH_A,
  input  logic             LAUNCH_B,
  output logic             RED,
  output logic             YELLOW,
  output logic             GREEN,
  output logic             FOUL_A,
  output logic             FOUL_B,
  output logic             WIN_A,
  output logic             WIN_B,
  output logic             TIE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] REACT,
  output logic             DONE
);

  localparam logic [CNT_W-1:0] AMBER_LAST   = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);

  race_state_t      state, next_state;
  race_flags_t      flags_q, flags_d;
  logic [CNT_W-1:0] react_q, react_d;
  logic [CNT_W-1:0] count;
  logic             red_d, yellow_d, green_d, done_d;
  logic             launch;
  logic             cnt_clear, cnt_enable;

  assign launch = LAUNCH_A || LAUNCH_B;

  // Counter restarts at 0 on AMBER entry and again on the AMBER->GO hand-off.
  assign cnt_clear  = ((state != AMBER) && (state != GO)) ||
                      ((state == AMBER) && (next_state == GO));
  assign cnt_enable = (state == AMBER) || (state == GO);

  race_cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .clk    (CLOCK),
    .rst    (RESET),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (count)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (START && STAGE_A && STAGE_B) next_state = AMBER;
      AMBER:  if (launch) next_state = RESULT;
              else if (count == AMBER_LAST) next_state = GO;
      GO:     if (launch || (count == TIMEOUT_LAST)) next_state = RESULT;
      RESULT: if (!STAGE_A && !STAGE_B) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of every output register, decoded from the state being entered.
  always_comb begin
    flags_d = flags_q;
    react_d = react_q;
    case (state)
      AMBER: begin
        if (launch) begin
          flags_d.foul_a = LAUNCH_A;
          flags_d.foul_b = LAUNCH_B;
          flags_d.win_a  = LAUNCH_B && !LAUNCH_A;
          flags_d.win_b  = LAUNCH_A && !LAUNCH_B;
        end
      end
      GO: begin
        if (launch) begin
          flags_d.win_a = LAUNCH_A && !LAUNCH_B;
          flags_d.win_b = LAUNCH_B && !LAUNCH_A;
          flags_d.tie   = LAUNCH_A && LAUNCH_B;
          react_d       = count;
        end else if (count == TIMEOUT_LAST) begin
          flags_d.timeout = 1'b1;
          react_d         = TIMEOUT_VAL;
        end
      end
      default: ;
    endcase
    if (next_state == IDLE) begin
      flags_d = '0;
      react_d = '0;
    end
    red_d    = (next_state == IDLE) ||
               ((next_state == RESULT) && (flags_d.foul_a || flags_d.foul_b));
    yellow_d = (next_state == AMBER);
    green_d  = (next_state == GO);
    done_d   = (next_state == RESULT);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      flags_q <= '0;
      react_q <= '0;
      RED     <= 1'b1;
      YELLOW  <= 1'b0;
      GREEN   <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      flags_q <= flags_d;
      react_q <= react_d;
      RED     <= red_d;
      YELLOW  <= yellow_d;
      GREEN   <= green_d;
      DONE    <= done_d;
    end
  end

  assign FOUL_A  = flags_q.foul_a;
  assign FOUL_B  = flags_q.foul_b;
  assign WIN_A   = flags_q.win_a;
  assign WIN_B   = flags_q.win_b;
  assign TIE     = flags_q.tie;
  assign TIMEOUT = flags_q.timeout;
  assign REACT   = react_q;

endmodule

// File: doc/drag_tree_controller.md
DRAG_TREE_CONTROLLER -- requirements
Module: drag_tree_controller

Interface
REQ-001 SHALL have parameter AMBER_CYCLES, default 3, meaning number of cycles YELLOW is lit before GREEN (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning number of GREEN cycles without any launch before the run aborts (legal range 1..255).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the internal counter and of REACT.
REQ-004 CLOCK  input  1  single system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 START  input  1  race start request, level-sampled.
REQ-007 STAGE_A / STAGE_B  input  1 each  lane A/B car staged at the line.
REQ-008 LAUNCH_A / LAUNCH_B  input  1 each  lane A/B car has left the line.
REQ-009 RED / YELLOW / GREEN  output  1 each  shared light tree, one-hot or all-off.
REQ-010 FOUL_A / FOUL_B  output  1 each  lane launched before GREEN.
REQ-011 WIN_A / WIN_B / TIE / TIMEOUT  output  1 each  race result flags.
REQ-012 REACT  output  CNT_W  GREEN cycles until the winning launch.
REQ-013 DONE  output  1  result valid.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, AMBER, GO, RESULT; all outputs SHALL be registered.
REQ-015 IDLE: RED=1; the block SHALL enter AMBER on the edge where START=1, STAGE_A=1 and STAGE_B=1; START with either lane unstaged SHALL be ignored.
REQ-016 On AMBER entry the counter SHALL clear to 0; YELLOW=1 SHALL appear in the cycle after the START sample (1-cycle latency).
REQ-017 AMBER: counter SHALL increment each cycle; after exactly AMBER_CYCLES cycles in AMBER, the block SHALL enter GO with the counter cleared.
REQ-018 LAUNCH_x=1 sampled in any AMBER cycle, including the last, SHALL set FOUL_x and go to RESULT on that edge; the non-fouling lane's WIN SHALL be set; simultaneous fouls SHALL set both FOUL flags and no WIN.
REQ-019 GO: GREEN=1; the counter SHALL count GO cycles starting at 0 in the first GO cycle.
REQ-020 The first lane sampled with LAUNCH=1 in GO SHALL set its WIN flag; REACT SHALL capture the counter value of that cycle; go to RESULT.
REQ-021 Both launches sampled in the same GO cycle SHALL set TIE=1, WIN_A=WIN_B=0, and capture REACT.
REQ-022 No launch within TIMEOUT_CYCLES GO cycles SHALL set TIMEOUT=1 and REACT=TIMEOUT_CYCLES, with no WIN flag; go to RESULT.
REQ-023 RESULT: DONE=1; RED=1 if any FOUL is set, otherwise all lights off; all result flags and REACT SHALL hold.
REQ-024 The block SHALL leave RESULT for IDLE when STAGE_A=0 and STAGE_B=0; result flags, REACT and DONE SHALL clear on IDLE entry.
REQ-025 Staging inputs dropping during AMBER or GO SHALL NOT alter the sequence; only LAUNCH inputs determine the outcome.
REQ-026 The counter SHALL saturate at its maximum value and never wrap.

Reset
REQ-027 RESET=1 SHALL force IDLE immediately, independent of CLOCK, in any state, including mid-AMBER or mid-GO.
REQ-028 Reset values: RED=1; YELLOW=GREEN=0; all FOUL, WIN, TIE, TIMEOUT and DONE=0; REACT=0.

Structure
REQ-029 A shared package race_pkg SHALL hold the state encoding and the default AMBER_CYCLES, TIMEOUT_CYCLES and CNT_W constants.
REQ-030 The counter SHALL be a sub-module race_cycle_counter with clear, enable and saturation, and a CNT_W-bit output.

Verification
REQ-031 Both lanes staged, START at cycle 2, LAUNCH_A in GO cycle 4 -> YELLOW for 3 cycles, then GREEN, then WIN_A=1, REACT=4, DONE=1.
REQ-032 LAUNCH_B asserted in the 2nd AMBER cycle -> FOUL_B=1, WIN_A=1, RED=1, GREEN never asserted.
REQ-033 LAUNCH_A and LAUNCH_B in the same GO cycle 2 -> TIE=1, WIN_A=WIN_B=0, REACT=2.
REQ-034 No launches -> GREEN for 15 cycles, then TIMEOUT=1, REACT=15, all lights off.
REQ-035 START with only STAGE_A=1 -> remains in IDLE with RED=1; RESET pulsed mid-GO -> RED=1 and all flags 0 before the next CLOCK edge.
REQ-036 From RESULT, lower both STAGE inputs -> IDLE in 1 cycle with DONE=0; a second race then runs correctly.
